alu_operand_stage: RTL and testbench

Upstream neighbour of the ALU hold register. Latches the A and B operands from the internal buses and executes one ALU operation per start request. Binary operations take one compute cycle; decimal-mode addition takes an extra adjust cycle. Drives the 8-bit result and a one-cycle resultValid strobe, which is wired to the hold register's read enable.

---
 rtl/alu_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Purpose : A/B operand latches plus a small FSM that runs one ALU op per start.
// Latency : start sampled at edge N -> resultValid after edge N+2 (binary), N+3 (decimal SUM).
// Backpres: no stall input; opStart while busy is dropped, loads only land when idle.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   aLoadZero, aLoadFromStackBus  A latch controls (zero wins), source stackBusInput
//   bLoadFromDataBus, bLoadFromAddressBusLow, bLoadInverted
//                                 B latch controls (data bus wins), optional inversion
//   opStart, opSelect, carryIn, decimalEnable
//                                 operation request, captured when accepted
//   busy, resultValid, result, carryOut, overflowOut, halfCarryOut
//                                 registered status, result and flags
module alu_operand_stage #(
    parameter logic [7:0] defaultValue   = 8'h00,
    parameter bit         ENABLE_DECIMAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       aLoadFromStackBus,
    input  logic       aLoadZero,
    input  logic [7:0] stackBusInput,
    input  logic       bLoadFromDataBus,
    input  logic       bLoadFromAddressBusLow,
    input  logic       bLoadInverted,
    input  logic [7:0] dataBusInput,
    input  logic [7:0] addressBusLowInput,
    input  logic       opStart,
    input  logic [2:0] opSelect,
    input  logic       carryIn,
    input  logic       decimalEnable,
    output logic       busy,
    output logic       resultValid,
    output logic [7:0] result,
    output logic       carryOut,
    output logic       overflowOut,
    output logic       halfCarryOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        ADJUST  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;

    state_t     state;
    logic [7:0] aReg;
    logic [7:0] bReg;
    logic [2:0] opReg;
    logic       cinReg;
    logic       decReg;

    // B source mux ahead of the optional inversion
    logic [7:0] bSource;
    logic       bLoad;

    // Binary-stage results
    logic [8:0] sum9;
    logic [4:0] lowSum;
    logic [7:0] aluResult;
    logic       aluCarry;
    logic       aluOverflow;
    logic       aluHalf;
    logic       wantAdjust;

    // Decimal-adjust results, computed from the registered binary result
    logic [7:0] adjStep1;
    logic [7:0] adjResult;
    logic       adjCarry;

    always_comb begin
        bSource = bLoadFromDataBus ? dataBusInput : addressBusLowInput;
        bLoad   = bLoadFromDataBus | bLoadFromAddressBusLow;
    end

    always_comb begin
        sum9        = {1'b0, aReg} + {1'b0, bReg} + {8'b0, cinReg};
        lowSum      = {1'b0, aReg[3:0]} + {1'b0, bReg[3:0]} + {4'b0, cinReg};
        aluResult   = 8'h00;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        aluHalf     = 1'b0;
        case (opReg)
            OP_SUM: begin
                aluResult   = sum9[7:0];
                aluCarry    = sum9[8];
                aluHalf     = lowSum[4];
                // Signed overflow: like-signed operands producing an opposite-signed result
                aluOverflow = (aReg[7] == bReg[7]) && (sum9[7] != aReg[7]);
            end
            OP_AND: aluResult = aReg & bReg;
            OP_OR:  aluResult = aReg | bReg;
            OP_XOR: aluResult = aReg ^ bReg;
            OP_SHR: begin
                aluResult = {cinReg, aReg[7:1]};
                aluCarry  = aReg[0];
            end
            default: begin
                aluResult = 8'h00;
            end
        endcase
        wantAdjust = ENABLE_DECIMAL && (opReg == OP_SUM) && decReg;
    end

    always_comb begin
        // Low nibble first; the high-nibble test looks at the already corrected value
        adjStep1  = ((result[3:0] > 4'd9) || halfCarryOut) ? (result + 8'h06) : result;
        adjResult = adjStep1;
        adjCarry  = carryOut;
        if ((adjStep1[7:4] > 4'd9) || carryOut) begin
            adjResult = adjStep1 + 8'h60;
            adjCarry  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            aReg         <= defaultValue;
            bReg         <= defaultValue;
            opReg        <= 3'd0;
            cinReg       <= 1'b0;
            decReg       <= 1'b0;
            busy         <= 1'b0;
            resultValid  <= 1'b0;
            result       <= 8'h00;
            carryOut     <= 1'b0;
            overflowOut  <= 1'b0;
            halfCarryOut <= 1'b0;
        end else begin
            resultValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (aLoadZero) begin
                        aReg <= 8'h00;
                    end else if (aLoadFromStackBus) begin
                        aReg <= stackBusInput;
                    end
                    if (bLoad) begin
                        bReg <= bLoadInverted ? ~bSource : bSource;
                    end
                    // busy also covers the resultValid cycle, which is spent here
                    busy <= opStart;
                    if (opStart) begin
                        opReg  <= opSelect;
                        cinReg <= carryIn;
                        decReg <= decimalEnable;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    result       <= aluResult;
                    carryOut     <= aluCarry;
                    overflowOut  <= aluOverflow;
                    halfCarryOut <= aluHalf;
                    state        <= wantAdjust ? ADJUST : DONE;
                end
                ADJUST: begin
                    result   <= adjResult;
                    carryOut <= adjCarry;
                    state    <= DONE;
                end
                DONE: begin
                    resultValid <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Purpose : directed checks of alu_operand_stage (decimal and non-decimal builds side by side).
// Latency : each operation is observed for a fixed window after its start edge.
// Backpres: none; start requests during busy are injected on purpose.
module tb_alu_operand_stage;

    logic       clk;
    logic       rst;
    logic       aLoadFromStackBus;
    logic       aLoadZero;
    logic [7:0] stackBusInput;
    logic       bLoadFromDataBus;
    logic       bLoadFromAddressBusLow;
    logic       bLoadInverted;
    logic [7:0] dataBusInput;
    logic [7:0] addressBusLowInput;
    logic       opStart;
    logic [2:0] opSelect;
    logic       carryIn;
    logic       decimalEnable;

    logic       busy, resultValid, carryOut, overflowOut, halfCarryOut;
    logic [7:0] result;
    logic       nd_busy, nd_resultValid, nd_carryOut, nd_overflowOut, nd_halfCarryOut;
    logic [7:0] nd_result;

    int total = 0;
    int bad   = 0;
    int lat, lat_nd, bcnt, rvcnt;
    logic [7:0] nd_res;
    logic       nd_c, nd_v;

    alu_operand_stage #(.defaultValue(8'h00), .ENABLE_DECIMAL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .aLoadFromStackBus(aLoadFromStackBus), .aLoadZero(aLoadZero),
        .stackBusInput(stackBusInput),
        .bLoadFromDataBus(bLoadFromDataBus), .bLoadFromAddressBusLow(bLoadFromAddressBusLow),
        .bLoadInverted(bLoadInverted), .dataBusInput(dataBusInput),
        .addressBusLowInput(addressBusLowInput),
        .opStart(opStart), .opSelect(opSelect), .carryIn(carryIn),
        .decimalEnable(decimalEnable),
        .busy(busy), .resultValid(resultValid), .result(result),
        .carryOut(carryOut), .overflowOut(overflowOut), .halfCarryOut(halfCarryOut)
    );

    alu_operand_stage #(.defaultValue(8'h5A), .ENABLE_DECIMAL(1'b0)) dut_nd (
        .clk(clk), .rst(rst),
        .aLoadFromStackBus(aLoadFromStackBus), .aLoadZero(aLoadZero),
        .stackBusInput(stackBusInput),
        .bLoadFromDataBus(bLoadFromDataBus), .bLoadFromAddressBusLow(bLoadFromAddressBusLow),
        .bLoadInverted(bLoadInverted), .dataBusInput(dataBusInput),
        .addressBusLowInput(addressBusLowInput),
        .opStart(opStart), .opSelect(opSelect), .carryIn(carryIn),
        .decimalEnable(decimalEnable),
        .busy(nd_busy), .resultValid(nd_resultValid), .result(nd_result),
        .carryOut(nd_carryOut), .overflowOut(nd_overflowOut), .halfCarryOut(nd_halfCarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_loads();
        aLoadFromStackBus      = 1'b0;
        aLoadZero              = 1'b0;
        bLoadFromDataBus       = 1'b0;
        bLoadFromAddressBusLow = 1'b0;
        bLoadInverted          = 1'b0;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        aLoadFromStackBus = 1'b1;
        stackBusInput     = a;
        bLoadFromDataBus  = 1'b1;
        dataBusInput      = b;
    endtask

    // Pulses opStart (with whatever loads are already set up) and watches a
    // 12-cycle window: latency in edges after the start edge, busy cycles
    // up to and including resultValid, and the number of resultValid pulses.
    task automatic run_op(input logic [2:0] sel, input logic cin, input logic dec);
        opSelect      = sel;
        carryIn       = cin;
        decimalEnable = dec;
        opStart       = 1'b1;
        @(posedge clk); #1;
        opStart = 1'b0;
        clear_loads();
        lat = -1; lat_nd = -1; bcnt = 0; rvcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (lat < 0 && busy) bcnt++;
            if (resultValid) begin
                rvcnt++;
                if (lat < 0) lat = c;
            end
            if (nd_resultValid && lat_nd < 0) begin
                lat_nd = c;
                nd_res = nd_result;
                nd_c   = nd_carryOut;
                nd_v   = nd_overflowOut;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_loads();
        stackBusInput = 8'h00; dataBusInput = 8'h00; addressBusLowInput = 8'h00;
        opStart = 1'b0; opSelect = 3'd0; carryIn = 1'b0; decimalEnable = 1'b0;
        nd_res = 8'h00; nd_c = 1'b0; nd_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, resultValid, carryOut, overflowOut, halfCarryOut, 3'b0, result}, 16'h0000);
        chk("rst_outputs_nd", {nd_busy, nd_resultValid, nd_carryOut, nd_overflowOut, nd_halfCarryOut, 3'b0, nd_result}, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0x50 + 0x50: signed overflow, no carry
        load_ab(8'h50, 8'h50);
        run_op(3'd0, 1'b0, 1'b0);
        chk("sum50_result", {8'h0, result}, 16'h00A0);
        chk("sum50_flags", {13'h0, carryOut, overflowOut, halfCarryOut}, 16'h0002);
        chk("sum50_latency", lat[15:0], 16'd2);
        chk("sum50_busy_cycles", bcnt[15:0], 16'd3);
        chk("sum50_one_strobe", rvcnt[15:0], 16'd1);
        chk("sum50_busy_after", {15'h0, busy}, 16'h0000);

        // Decimal 58 + 46 + 1 = 105; non-decimal build gives plain binary 0x9F
        load_ab(8'h58, 8'h46);
        run_op(3'd0, 1'b1, 1'b1);
        chk("bcd_result", {8'h0, result}, 16'h0005);
        chk("bcd_carry", {15'h0, carryOut}, 16'h0001);
        chk("bcd_latency", lat[15:0], 16'd3);
        chk("bcd_busy_cycles", bcnt[15:0], 16'd4);
        chk("nd_result", {8'h0, nd_res}, 16'h009F);
        chk("nd_carry", {15'h0, nd_c}, 16'h0000);
        chk("nd_latency", lat_nd[15:0], 16'd2);

        // Subtract 0x10 - 0x01 via inverted B and carry-in
        load_ab(8'h10, 8'h01);
        bLoadInverted = 1'b1;
        run_op(3'd0, 1'b1, 1'b0);
        chk("sub_result", {8'h0, result}, 16'h000F);
        chk("sub_flags", {13'h0, carryOut, overflowOut, halfCarryOut}, 16'h0004);

        // SHR 0x81 with shift-in 1
        load_ab(8'h81, 8'h00);
        run_op(3'd4, 1'b1, 1'b0);
        chk("shr_result", {8'h0, result}, 16'h00C0);
        chk("shr_carry", {15'h0, carryOut}, 16'h0001);

        // aLoadZero beats aLoadFromStackBus; OR with B=0x3C exposes A
        load_ab(8'hFF, 8'h3C);
        aLoadZero = 1'b1;
        run_op(3'd2, 1'b0, 1'b0);
        chk("or_zero_result", {8'h0, result}, 16'h003C);

        // Data bus beats address bus low; AND 0xF0 & 0x3C
        load_ab(8'hF0, 8'h3C);
        bLoadFromAddressBusLow = 1'b1;
        addressBusLowInput     = 8'hFF;
        run_op(3'd1, 1'b0, 1'b0);
        chk("and_result", {8'h0, result}, 16'h0030);
        chk("and_flags", {13'h0, carryOut, overflowOut, halfCarryOut}, 16'h0000);

        // Reserved op: zero result, handshake completes
        load_ab(8'hFF, 8'hFF);
        run_op(3'd6, 1'b1, 1'b1);
        chk("rsv_result", {8'h0, result}, 16'h0000);
        chk("rsv_latency", lat[15:0], 16'd2);

        // Busy window: extra start + B load during COMPUTE, extra start during DONE
        load_ab(8'h50, 8'h50);
        opSelect = 3'd0; carryIn = 1'b0; decimalEnable = 1'b0;
        opStart  = 1'b1;
        @(posedge clk); #1;
        clear_loads();
        chk("busy_in_compute", {15'h0, busy}, 16'h0001);
        opStart = 1'b1; bLoadFromDataBus = 1'b1; dataBusInput = 8'hFF;
        @(posedge clk); #1;
        bLoadFromDataBus = 1'b0;
        opStart = 1'b1;
        @(posedge clk); #1;
        opStart = 1'b0;
        chk("busy_first_valid", {15'h0, resultValid}, 16'h0001);
        chk("busy_first_result", {8'h0, result}, 16'h00A0);
        rvcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (resultValid) rvcnt++;
        end
        chk("busy_no_second_valid", rvcnt[15:0], 16'd0);
        // B should still be 0x50: 0x0F ^ 0x50 = 0x5F
        aLoadFromStackBus = 1'b1; stackBusInput = 8'h0F;
        run_op(3'd3, 1'b0, 1'b0);
        chk("busy_b_unchanged", {8'h0, result}, 16'h005F);

        // Reset while in ADJUST aborts the operation
        load_ab(8'h58, 8'h46);
        opSelect = 3'd0; carryIn = 1'b1; decimalEnable = 1'b1;
        opStart  = 1'b1;
        @(posedge clk); #1;
        opStart = 1'b0;
        clear_loads();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, resultValid, carryOut, overflowOut, halfCarryOut, 3'b0, result}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        rvcnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (resultValid) rvcnt++;
        end
        chk("abort_no_valid", rvcnt[15:0], 16'd0);

        // After reset operands are defaultValue: 0x00 here, 0x5A in the other build
        run_op(3'd0, 1'b0, 1'b0);
        chk("post_rst_latency", lat[15:0], 16'd2);
        chk("post_rst_result", {8'h0, result}, 16'h0000);
        chk("post_rst_nd_result", {8'h0, nd_res}, 16'h00B4);
        chk("post_rst_nd_ovf", {15'h0, nd_v}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
